// File: rtl/usb_annunciator_pkg.sv
// Shared encodings and default timing constants for the annunciator UART TX slice.
// USB_ANNUN_TX_PARITY_EN adds the even-parity state to the TX encoding.
package usb_annunciator_pkg;

  localparam int CLK_DIV_DEFAULT   = 417;
  localparam int FETCH_LAT_DEFAULT = 3;
  localparam int ANNUN_LAT         = 2;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_DROP
  } fetch_state_t;

`ifdef USB_ANNUN_TX_PARITY_EN
  typedef enum logic [2:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_PAR,
    T_STOP
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    T_IDLE,
    T_START,
    T_DATA,
    T_STOP
  } tx_state_t;
`endif

endpackage

// File: rtl/usb_baud_gen.sv
// Bit-period down-counter: tick marks the last clk48 cycle of a bit, pre_tick the one before.
// Independent of USB_ANNUN_TX_PARITY_EN.
module usb_baud_gen #(
  parameter int CLK_DIV = 417
) (
  input  logic clk48,
  input  logic rst_n,
  input  logic restart,
  output logic tick,
  output logic pre_tick
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
    end else if (restart || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - W'(1);
    end
  end

  assign tick     = (cnt == '0);
  assign pre_tick = (cnt == W'(1));

endmodule

// File: rtl/usb_annunciator_uart_tx.sv
// Pulls status bytes from the annunciator and sends them as 8N1 UART frames, one byte prefetched.
// Define USB_ANNUN_TX_PARITY_EN to append an even-parity bit (8E1).
//
// state   | meaning
// F_IDLE  | no fetch in progress; starts one when enabled and the hold is empty
// F_REQ   | inc high, counting down to the din sample cycle
// F_DROP  | one forced inc-low cycle after every fetch
// T_IDLE  | line idle high, waiting for a held byte
// T_START | start bit (low)
// T_DATA  | eight data bits, LSB first
// T_PAR   | even parity bit (parity build only)
// T_STOP  | stop bit (high); chains straight into T_START if a byte is held
module usb_annunciator_uart_tx
  import usb_annunciator_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEFAULT,
  parameter int FETCH_LAT = FETCH_LAT_DEFAULT
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic       en,
  output logic       inc,
  input  logic [7:0] din,
  input  logic       din_v,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int FW = $clog2(FETCH_LAT + 1);

  if (CLK_DIV < 2 || FETCH_LAT < ANNUN_LAT + 1) begin : g_bad_param
    $error("usb_annunciator_uart_tx: CLK_DIV must be >= 2 and FETCH_LAT > annunciator latency");
  end

  fetch_state_t  f_state;
  tx_state_t     t_state;
  logic [FW-1:0] f_cnt;
  logic [7:0]    hold;
  logic          hold_full;
  logic [7:0]    shift;
  logic [2:0]    idx;
`ifdef USB_ANNUN_TX_PARITY_EN
  logic          par;
`endif

  logic tick, pre_tick;
  logic capture, load, hold_full_nxt, busy_nxt;

  // Next-cycle view of the busy terms so busy can leave a flop like every other output.
  always_comb begin
    capture       = (f_state == F_REQ) && (f_cnt == FW'(1)) && din_v;
    load          = hold_full && ((t_state == T_IDLE) || (t_state == T_STOP && tick));
    hold_full_nxt = capture || (hold_full && !load);
    busy_nxt      = hold_full_nxt
                 || (f_state == F_REQ)
                 || (f_state == F_IDLE && en && !hold_full)
                 || load
                 || (t_state != T_IDLE && !(t_state == T_STOP && tick));
  end

  usb_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk48    (clk48),
    .rst_n    (rst_n),
    .restart  (load),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      busy      <= 1'b0;
    end else begin
      hold_full <= hold_full_nxt;
      busy      <= busy_nxt;
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      f_state <= F_IDLE;
      inc     <= 1'b0;
      f_cnt   <= '0;
      hold    <= '0;
    end else begin
      case (f_state)
        F_IDLE: begin
          if (en && !hold_full) begin
            f_state <= F_REQ;
            inc     <= 1'b1;
            f_cnt   <= FW'(FETCH_LAT);
          end
        end
        F_REQ: begin
          f_cnt <= f_cnt - FW'(1);
          // counter reaches 0 on this edge: sample din; an invalid byte is simply dropped
          if (f_cnt == FW'(1)) begin
            inc     <= 1'b0;
            f_state <= F_DROP;
            if (din_v) hold <= din;
          end
        end
        F_DROP:  f_state <= F_IDLE;
        default: begin
          f_state <= F_IDLE;
          inc     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      t_state    <= T_IDLE;
      tx         <= 1'b1;
      frame_done <= 1'b0;
      shift      <= '0;
      idx        <= '0;
`ifdef USB_ANNUN_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      frame_done <= (t_state == T_STOP) && pre_tick;
      case (t_state)
        T_IDLE: begin
          if (load) begin
            t_state <= T_START;
            tx      <= 1'b0;
            shift   <= hold;
            idx     <= '0;
`ifdef USB_ANNUN_TX_PARITY_EN
            par     <= ^hold;
`endif
          end
        end
        T_START: begin
          if (tick) begin
            t_state <= T_DATA;
            tx      <= shift[0];
            shift   <= {1'b0, shift[7:1]};
          end
        end
        T_DATA: begin
          if (tick) begin
            if (idx == 3'd7) begin
`ifdef USB_ANNUN_TX_PARITY_EN
              t_state <= T_PAR;
              tx      <= par;
`else
              t_state <= T_STOP;
              tx      <= 1'b1;
`endif
            end else begin
              idx   <= idx + 3'd1;
              tx    <= shift[0];
              shift <= {1'b0, shift[7:1]};
            end
          end
        end
`ifdef USB_ANNUN_TX_PARITY_EN
        T_PAR: begin
          if (tick) begin
            t_state <= T_STOP;
            tx      <= 1'b1;
          end
        end
`endif
        T_STOP: begin
          if (tick) begin
            if (load) begin
              t_state <= T_START;
              tx      <= 1'b0;
              shift   <= hold;
              idx     <= '0;
`ifdef USB_ANNUN_TX_PARITY_EN
              par     <= ^hold;
`endif
            end else begin
              t_state <= T_IDLE;
            end
          end
        end
        default: begin
          t_state <= T_IDLE;
          tx      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_annunciator_uart_tx.sv
// Self-checking bench: annunciator model feeds random/directed bytes, a line decoder checks every frame.
// Honours USB_ANNUN_TX_PARITY_EN for the expected frame layout.
`timescale 1ns/1ps
module tb_usb_annunciator_uart_tx;

  localparam int CLK_DIV   = 4;
  localparam int FETCH_LAT = 3;
`ifdef USB_ANNUN_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CLK_DIV;

  logic       clk48 = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       din_v = 1'b0;
  logic [7:0] din   = 8'h00;
  logic       inc, tx, busy, frame_done;

  always #5 clk48 = ~clk48;

  usb_annunciator_uart_tx #(.CLK_DIV(CLK_DIV), .FETCH_LAT(FETCH_LAT)) dut (
    .clk48      (clk48),
    .rst_n      (rst_n),
    .en         (en),
    .inc        (inc),
    .din        (din),
    .din_v      (din_v),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] force_b[$];
  logic       force_v[$];
  bit         rand_invalid = 1'b0;
  int inc_rises = 0, frames_started = 0, frames_ended = 0;
  int ncyc = 0, last_rise_cyc = 0, last_start_cyc = 0, last_gap = 0;
  int pos = 0, stray_fd = 0;
  bit in_frame = 1'b0;

  initial forever begin
    @(posedge clk48);
    ncyc = ncyc + 1;
  end

  // Annunciator: presents a byte as soon as a request is seen, holds it until inc falls.
  initial begin : annunciator
    logic       prev;
    logic       v;
    logic [7:0] b;
    prev = 1'b0;
    forever begin
      @(negedge clk48);
      if (!rst_n) begin
        din_v = 1'b0;
        prev  = 1'b0;
        exp_q.delete();
      end else begin
        if (inc && !prev) begin
          if (force_v.size() > 0) begin
            v = force_v.pop_front();
            b = force_b.pop_front();
          end else begin
            b = 8'($urandom);
            v = rand_invalid ? ($urandom_range(0, 4) != 0) : 1'b1;
          end
          din   = b;
          din_v = v;
          if (v) exp_q.push_back(b);
          inc_rises     = inc_rises + 1;
          last_rise_cyc = ncyc;
        end else if (!inc && prev) begin
          din_v = 1'b0;
          din   = 8'($urandom);
        end
        prev = inc;
      end
    end
  end

  // Line decoder: each frame must match the next byte the annunciator handed out.
  initial begin : line_monitor
    int idle_run, inc_run, ferr, k;
    logic [7:0] fb, dec;
    logic exp_line;
    idle_run = 0; inc_run = 0; ferr = 0; fb = 8'h00; dec = 8'h00;
    forever begin
      @(negedge clk48);
      if (!rst_n) begin
        in_frame = 1'b0;
        inc_run  = 0;
        idle_run = 0;
      end else begin
        if (inc) inc_run++;
        else if (inc_run > 0) begin
          check_val("inc_width", 32'(inc_run), 32'(FETCH_LAT));
          inc_run = 0;
        end
        if (!in_frame && tx === 1'b0) begin
          in_frame       = 1'b1;
          pos            = 0;
          ferr           = 0;
          dec            = 8'h00;
          last_gap       = idle_run;
          idle_run       = 0;
          last_start_cyc = ncyc;
          frames_started = frames_started + 1;
          if (exp_q.size() == 0) begin
            check_val("unexpected_frame", 32'd1, 32'd0);
            fb = 8'h00;
          end else begin
            fb = exp_q.pop_front();
          end
        end
        if (in_frame) begin
          k = pos / CLK_DIV;
          if (k == 0) exp_line = 1'b0;
          else if (k <= 8) exp_line = fb[k-1];
          else if (k == NBITS - 1) exp_line = 1'b1;
          else exp_line = ^fb;
          if (k >= 1 && k <= 8 && (pos % CLK_DIV) == CLK_DIV / 2) dec[k-1] = tx;
          if (tx !== exp_line) ferr++;
          if (frame_done !== (pos == FRAME - 1)) ferr++;
          if (busy !== 1'b1) ferr++;
          pos++;
          if (pos == FRAME) begin
            check_val("frame_byte", 32'(dec), 32'(fb));
            check_val("frame_line_errs", 32'(ferr), 32'd0);
            in_frame     = 1'b0;
            frames_ended = frames_ended + 1;
          end
        end else begin
          if (frame_done !== 1'b0) stray_fd++;
          idle_run++;
        end
      end
    end
  end

  task automatic wait_ended(input int n, input string tag);
    for (int i = 0; i < 4 * FRAME + 40 && frames_ended < n; i++) @(negedge clk48);
    check_val(tag, 32'(frames_ended), 32'(n));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 4 * FRAME + 40 && (busy !== 1'b0 || in_frame); i++) @(negedge clk48);
    check_val(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_rises(input int n, input string tag);
    for (int i = 0; i < 4 * FRAME + 40 && inc_rises < n; i++) @(negedge clk48);
    check_val(tag, 32'(inc_rises), 32'(n));
  endtask

  initial begin : main
    int base_r, base_f, d;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk48);
    check_val("rst_tx", {31'd0, tx}, 32'd1);
    check_val("rst_inc", {31'd0, inc}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk48);

    // single byte, en pulsed for one edge
    force_b.push_back(8'h41); force_v.push_back(1'b1);
    en = 1'b1;
    @(negedge clk48);
    en = 1'b0;
    wait_ended(1, "single_frames");
    wait_idle("single_idle");
    check_val("single_rises", 32'(inc_rises), 32'd1);

    // back to back, then en dropped while byte 1 is on the line and byte 2 is held
    base_r = inc_rises; base_f = frames_ended;
    force_b.push_back(8'h55); force_v.push_back(1'b1);
    force_b.push_back(8'hAA); force_v.push_back(1'b1);
    en = 1'b1;
    wait_rises(base_r + 2, "b2b_second_req");
    d = last_rise_cyc - last_start_cyc;
    check_val("b2b_rise_in_start", 32'(d >= 0 && d < CLK_DIV), 32'd1);
    repeat (FETCH_LAT) @(negedge clk48);
    en = 1'b0;
    wait_ended(base_f + 2, "b2b_frames");
    check_val("b2b_gap", 32'(last_gap), 32'd0);
    wait_idle("b2b_idle");
    check_val("edrop_rises", 32'(inc_rises), 32'(base_r + 2));
    check_val("edrop_inc", {31'd0, inc}, 32'd0);

    // invalid data at the sample cycle, then a retry
    base_r = inc_rises; base_f = frames_ended;
    force_b.push_back(8'h3C); force_v.push_back(1'b0);
    force_b.push_back(8'h96); force_v.push_back(1'b1);
    en = 1'b1;
    wait_rises(base_r + 2, "inv_retry");
    repeat (FETCH_LAT) @(negedge clk48);
    en = 1'b0;
    wait_ended(base_f + 1, "inv_frames");
    wait_idle("inv_idle");
    check_val("inv_rises", 32'(inc_rises), 32'(base_r + 2));
    check_val("inv_queue", 32'(exp_q.size()), 32'd0);

    // asynchronous reset during data bit 3
    base_f = frames_started;
    force_b.push_back(8'h5A); force_v.push_back(1'b1);
    en = 1'b1;
    for (int i = 0; i < 4 * FRAME && !(frames_started > base_f && in_frame && pos >= 4 * CLK_DIV); i++)
      @(negedge clk48);
    check_val("rstmid_reached", 32'(in_frame && pos >= 4 * CLK_DIV), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rstmid_tx", {31'd0, tx}, 32'd1);
    check_val("rstmid_inc", {31'd0, inc}, 32'd0);
    check_val("rstmid_busy", {31'd0, busy}, 32'd0);
    en = 1'b0;
    repeat (3) @(negedge clk48);
    rst_n = 1'b1;
    base_f = frames_started;
    repeat (2 * FRAME) @(negedge clk48);
    check_val("rstmid_no_residual", 32'(frames_started), 32'(base_f));
    check_val("rstmid_line_idle", {31'd0, tx}, 32'd1);
    base_f = frames_ended;
    force_b.push_back(8'hC3); force_v.push_back(1'b1);
    en = 1'b1;
    @(negedge clk48);
    en = 1'b0;
    wait_ended(base_f + 1, "rstmid_next_frame");
    wait_idle("rstmid_idle");

    // randomized enable and data-valid traffic
    rand_invalid = 1'b1;
    base_f = frames_ended;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk48);
      if ($urandom_range(0, 59) == 0) en = ~en;
    end
    en = 1'b0;
    wait_idle("rand_idle");
    repeat (4) @(negedge clk48);
    check_val("rand_drained", 32'(exp_q.size()), 32'd0);
    check_val("rand_progress", 32'(frames_ended > base_f), 32'd1);
    check_val("rand_inc_low", {31'd0, inc}, 32'd0);
    check_val("stray_frame_done", 32'(stray_fd), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
